csc_stor_ctrl: RTL and testbench

Load sequencer for the CSC (compressed sparse column) matrix store. It accepts a column-major stream of nonzero coordinates and generates the write strobes and addresses for the value store (csc_stor), the row-index array and the column-pointer array. It fills pointers for empty columns and flushes the trailing pointers after the last entry. It also flags malformed input streams.

---
 rtl/csc_pkg.sv | 27 ++
 rtl/csc_stor_ctrl.sv | 171 +++++++++++++++++
 tb/tb_csc_stor_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/csc_pkg.sv
// Shared definitions for the CSC matrix store: load-sequencer states and
// the index/pointer/count width helpers used by both csc_stor and its controller.
package csc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      ERR   = 2'd3
   } csc_state_e;

   // Row/column index width: enough bits for 0..MAT_RANK-1.
   function automatic int csc_rw(input int mat_rank);
      return (mat_rank > 1) ? $clog2(mat_rank) : 1;
   endfunction

   // Column-pointer address width: enough bits for 0..MAT_RANK.
   function automatic int csc_pw(input int mat_rank);
      return $clog2(mat_rank + 1);
   endfunction

   // Nonzero count/slot width: enough bits for 0..NNZ_MAX.
   function automatic int csc_nw(input int nnz_max);
      return $clog2(nnz_max + 1);
   endfunction

endpackage

// File: rtl/csc_stor_ctrl.sv
// Load sequencer for the CSC matrix store. Takes a column-major stream of
// nonzero coordinates, emits value/row-index writes and column-pointer writes
// (including pointers for empty columns and the trailing flush), and traps
// malformed streams into a sticky error state.
module csc_stor_ctrl
   import csc_pkg::*;
#(
   parameter int  MAT_RANK = 256,
   parameter int  NNZ_MAX  = 4096,
   localparam int RW       = csc_rw(MAT_RANK),
   localparam int PW       = csc_pw(MAT_RANK),
   localparam int NW       = csc_nw(NNZ_MAX)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          ent_vld,
   output logic          ent_rdy,
   input  logic [RW-1:0] ent_row,
   input  logic [RW-1:0] ent_col,
   input  logic          ent_last,
   output logic          val_vld,
   output logic [NW-1:0] val_addr,
   output logic          row_we,
   output logic [NW-1:0] row_addr,
   output logic [RW-1:0] row_data,
   output logic          ptr_we,
   output logic [PW-1:0] ptr_addr,
   output logic [NW-1:0] ptr_data,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [NW-1:0] nnz
);

   csc_state_e    state, state_n;
   logic [PW-1:0] ptr_col, ptr_col_n;
   logic [NW-1:0] nnz_n;
   logic [RW-1:0] last_row, last_row_n;
   logic          new_col, new_col_n;
   logic          err_n;
   logic          ptr_issue;
   logic          done_n;

   logic [PW-1:0] col_ext;
   logic [PW-1:0] col_nxt;
   logic          col_open;
   logic          col_cur;
   logic          col_back;
   logic          nnz_full;
   logic          row_bad;

   // Column comparisons are done against ptr_col using ent_col+1 so that the
   // "current column" (ptr_col-1) never needs a subtraction that could wrap.
   assign col_ext  = PW'(ent_col);
   assign col_nxt  = col_ext + PW'(1);
   assign col_open = (col_ext >= ptr_col);
   assign col_cur  = (col_nxt == ptr_col);
   assign col_back = (col_nxt < ptr_col);
   assign nnz_full = (nnz == NW'(NNZ_MAX));
   assign row_bad  = !new_col && (ent_row <= last_row);

   assign busy     = (state == LOAD) || (state == FLUSH);
   assign val_vld  = row_we;
   assign val_addr = row_addr;

   // Next-state, handshake and write-issue decisions for the current cycle.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_n    = state;
      ptr_col_n  = ptr_col;
      nnz_n      = nnz;
      last_row_n = last_row;
      new_col_n  = new_col;
      err_n      = err;
      ent_rdy    = 1'b0;
      ptr_issue  = 1'b0;
      done_n     = 1'b0;
      case (state)
         IDLE, ERR: begin
            if (start) begin
               state_n   = LOAD;
               ptr_col_n = '0;
               nnz_n     = '0;
               new_col_n = 1'b1;
               err_n     = 1'b0;
            end
         end
         LOAD: begin
            if (ent_vld) begin
               if (col_open) begin
                  // Open the next column: its pointer is the current count.
                  ptr_issue = 1'b1;
                  ptr_col_n = ptr_col + PW'(1);
                  new_col_n = 1'b1;
               end else if (col_cur && nnz_full) begin
                  state_n = ERR;
                  err_n   = 1'b1;
               end else if (col_cur && row_bad) begin
                  state_n = ERR;
                  err_n   = 1'b1;
               end else if (col_back) begin
                  state_n = ERR;
                  err_n   = 1'b1;
               end else begin
                  ent_rdy    = 1'b1;
                  nnz_n      = nnz + NW'(1);
                  last_row_n = ent_row;
                  new_col_n  = 1'b0;
                  if (ent_last) state_n = FLUSH;
               end
            end
         end
         FLUSH: begin
            ptr_issue = 1'b1;
            ptr_col_n = ptr_col + PW'(1);
            if (ptr_col == PW'(MAT_RANK)) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Control state and load bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr_col  <= '0;
         nnz      <= '0;
         last_row <= '0;
         new_col  <= 1'b0;
         err      <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all registers update together.
         state    <= state_n;
         ptr_col  <= ptr_col_n;
         nnz      <= nnz_n;
         last_row <= last_row_n;
         new_col  <= new_col_n;
         err      <= err_n;
      end
   end

   // Registered write strobes; address/data hold their last written value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_we   <= 1'b0;
         row_addr <= '0;
         row_data <= '0;
         ptr_we   <= 1'b0;
         ptr_addr <= '0;
         ptr_data <= '0;
         done     <= 1'b0;
      end else begin
         row_we <= ent_rdy;
         ptr_we <= ptr_issue;
         done   <= done_n;
         if (ent_rdy) begin
            row_addr <= nnz;
            row_data <= ent_row;
         end
         if (ptr_issue) begin
            ptr_addr <= ptr_col;
            ptr_data <= nnz;
         end
      end
   end

endmodule

// File: tb/tb_csc_stor_ctrl.sv
// Self-checking bench for csc_stor_ctrl at MAT_RANK=4, NNZ_MAX=8: a
// cycle-by-cycle vector table for the ordinary and error loads, plus
// hand-written sequences for overflow and reset during flush.
module tb_csc_stor_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       ent_vld;
   logic       ent_rdy;
   logic [1:0] ent_row;
   logic [1:0] ent_col;
   logic       ent_last;
   logic       val_vld;
   logic [3:0] val_addr;
   logic       row_we;
   logic [3:0] row_addr;
   logic [1:0] row_data;
   logic       ptr_we;
   logic [2:0] ptr_addr;
   logic [3:0] ptr_data;
   logic       busy;
   logic       done;
   logic       err;
   logic [3:0] nnz;

   int n_cmp = 0;
   int n_bad = 0;

   csc_stor_ctrl #(.MAT_RANK(4), .NNZ_MAX(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .ent_vld(ent_vld), .ent_rdy(ent_rdy), .ent_row(ent_row),
      .ent_col(ent_col), .ent_last(ent_last),
      .val_vld(val_vld), .val_addr(val_addr),
      .row_we(row_we), .row_addr(row_addr), .row_data(row_data),
      .ptr_we(ptr_we), .ptr_addr(ptr_addr), .ptr_data(ptr_data),
      .busy(busy), .done(done), .err(err), .nnz(nnz)
   );

   always #5 clk = ~clk;

   // Write monitor: records the store images and counts done pulses.
   logic       mon_clr = 1'b1;
   logic [3:0] ptr_mem [0:7];
   logic [1:0] row_mem [0:15];
   int         done_cnt;

   always @(negedge clk) begin
      if (mon_clr) begin
         for (int i = 0; i < 8; i++)  ptr_mem[i] = 4'hF;
         for (int i = 0; i < 16; i++) row_mem[i] = 2'd0;
         done_cnt = 0;
      end else begin
         if (ptr_we) ptr_mem[ptr_addr] = ptr_data;
         if (row_we) row_mem[row_addr] = row_data;
         if (done)   done_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       st, vld;
      logic [1:0] row, col;
      logic       last;
      logic       rdy;
      logic       pwe;
      logic [2:0] pa;
      logic [3:0] pd;
      logic       rwe;
      logic [3:0] ra;
      logic [1:0] rd;
      logic       dn, bsy, er;
      logic [3:0] nz;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(int st, int vld, int row, int col, int last, int rdy,
                              int pwe, int pa, int pd, int rwe, int ra, int rd,
                              int dn, int bsy, int er, int nz);
      vec_t x;
      x.st = st[0]; x.vld = vld[0]; x.row = row[1:0]; x.col = col[1:0];
      x.last = last[0]; x.rdy = rdy[0]; x.pwe = pwe[0]; x.pa = pa[2:0];
      x.pd = pd[3:0]; x.rwe = rwe[0]; x.ra = ra[3:0]; x.rd = rd[1:0];
      x.dn = dn[0]; x.bsy = bsy[0]; x.er = er[0]; x.nz = nz[3:0];
      return x;
   endfunction

   task automatic mon_clear();
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start   = 1'b1;
      ent_vld = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Present one entry and hold it until accepted, within a cycle budget.
   task automatic send(input int r, input int c, input int last);
      bit got = 1'b0;
      @(negedge clk);
      ent_vld  = 1'b1;
      ent_row  = r[1:0];
      ent_col  = c[1:0];
      ent_last = last[0];
      for (int k = 0; k < 16 && !got; k++) begin
         #1 got = ent_rdy;
         @(posedge clk);
         if (!got) @(negedge clk);
      end
      check($sformatf("send_r%0d_c%0d_accepted", r, c), 32'(got), 32'd1);
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({ent_rdy, val_vld, val_addr, row_we, row_addr, row_data,
                  ptr_we, ptr_addr, ptr_data, busy, done, err, nnz});
   endfunction

   initial begin
      int rdy_seen;
      logic [3:0] exp_ptr [0:4];
      logic [1:0] exp_row [0:2];
      exp_ptr = '{4'd0, 4'd2, 4'd2, 4'd3, 4'd3};
      exp_row = '{2'd0, 2'd2, 2'd1};

      rst_n = 1'b0; start = 1'b0; ent_vld = 1'b0;
      ent_row = '0; ent_col = '0; ent_last = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("reset_outputs", all_outs(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 mon_clr = 1'b0;

      // Basic load: (r0,c0),(r2,c0),(r1,c2,last)
      tbl.push_back(v(1,0,0,0,0, 0, 0,0,0, 0,0,0, 0,1,0,0));
      tbl.push_back(v(0,1,0,0,0, 0, 1,0,0, 0,0,0, 0,1,0,0));
      tbl.push_back(v(0,1,0,0,0, 1, 0,0,0, 1,0,0, 0,1,0,1));
      tbl.push_back(v(0,1,2,0,0, 1, 0,0,0, 1,1,2, 0,1,0,2));
      tbl.push_back(v(0,1,1,2,1, 0, 1,1,2, 0,0,0, 0,1,0,2));
      tbl.push_back(v(0,1,1,2,1, 0, 1,2,2, 0,0,0, 0,1,0,2));
      tbl.push_back(v(0,1,1,2,1, 1, 0,0,0, 1,2,1, 0,1,0,3));
      tbl.push_back(v(0,0,0,0,0, 0, 1,3,3, 0,0,0, 0,1,0,3));
      tbl.push_back(v(0,0,0,0,0, 0, 1,4,3, 0,0,0, 1,0,0,3));
      tbl.push_back(v(0,0,0,0,0, 0, 0,0,0, 0,0,0, 0,0,0,3));
      // Leading empty columns: (r1,c3,last)
      tbl.push_back(v(1,0,0,0,0, 0, 0,0,0, 0,0,0, 0,1,0,0));
      tbl.push_back(v(0,1,1,3,1, 0, 1,0,0, 0,0,0, 0,1,0,0));
      tbl.push_back(v(0,1,1,3,1, 0, 1,1,0, 0,0,0, 0,1,0,0));
      tbl.push_back(v(0,1,1,3,1, 0, 1,2,0, 0,0,0, 0,1,0,0));
      tbl.push_back(v(0,1,1,3,1, 0, 1,3,0, 0,0,0, 0,1,0,0));
      tbl.push_back(v(0,1,1,3,1, 1, 0,0,0, 1,0,1, 0,1,0,1));
      tbl.push_back(v(0,0,0,0,0, 0, 1,4,1, 0,0,0, 1,0,0,1));
      // Column order violation: (r0,c2) then (r0,c1), then start clears err
      tbl.push_back(v(1,0,0,0,0, 0, 0,0,0, 0,0,0, 0,1,0,0));
      tbl.push_back(v(0,1,0,2,0, 0, 1,0,0, 0,0,0, 0,1,0,0));
      tbl.push_back(v(0,1,0,2,0, 0, 1,1,0, 0,0,0, 0,1,0,0));
      tbl.push_back(v(0,1,0,2,0, 0, 1,2,0, 0,0,0, 0,1,0,0));
      tbl.push_back(v(0,1,0,2,0, 1, 0,0,0, 1,0,0, 0,1,0,1));
      tbl.push_back(v(0,1,0,1,0, 0, 0,0,0, 0,0,0, 0,0,1,1));
      tbl.push_back(v(0,1,0,1,0, 0, 0,0,0, 0,0,0, 0,0,1,1));
      tbl.push_back(v(1,0,0,0,0, 0, 0,0,0, 0,0,0, 0,1,0,0));
      // Row order violation: (r2,c0) then (r2,c0)
      tbl.push_back(v(0,1,2,0,0, 0, 1,0,0, 0,0,0, 0,1,0,0));
      tbl.push_back(v(0,1,2,0,0, 1, 0,0,0, 1,0,2, 0,1,0,1));
      tbl.push_back(v(0,1,2,0,0, 0, 0,0,0, 0,0,0, 0,0,1,1));
      tbl.push_back(v(0,0,0,0,0, 0, 0,0,0, 0,0,0, 0,0,1,1));

      foreach (tbl[i]) begin
         @(negedge clk);
         start    = tbl[i].st;
         ent_vld  = tbl[i].vld;
         ent_row  = tbl[i].row;
         ent_col  = tbl[i].col;
         ent_last = tbl[i].last;
         #1 check($sformatf("v%0d.ent_rdy", i), 32'(ent_rdy), 32'(tbl[i].rdy));
         @(posedge clk);
         #1;
         check($sformatf("v%0d.ptr_we", i), 32'(ptr_we), 32'(tbl[i].pwe));
         if (tbl[i].pwe) begin
            check($sformatf("v%0d.ptr_addr", i), 32'(ptr_addr), 32'(tbl[i].pa));
            check($sformatf("v%0d.ptr_data", i), 32'(ptr_data), 32'(tbl[i].pd));
         end
         check($sformatf("v%0d.row_we", i), 32'(row_we), 32'(tbl[i].rwe));
         check($sformatf("v%0d.val_vld", i), 32'(val_vld), 32'(tbl[i].rwe));
         if (tbl[i].rwe) begin
            check($sformatf("v%0d.row_addr", i), 32'(row_addr), 32'(tbl[i].ra));
            check($sformatf("v%0d.val_addr", i), 32'(val_addr), 32'(tbl[i].ra));
            check($sformatf("v%0d.row_data", i), 32'(row_data), 32'(tbl[i].rd));
         end
         check($sformatf("v%0d.done", i), 32'(done), 32'(tbl[i].dn));
         check($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].bsy));
         check($sformatf("v%0d.err", i), 32'(err), 32'(tbl[i].er));
         check($sformatf("v%0d.nnz", i), 32'(nnz), 32'(tbl[i].nz));
      end
      @(negedge clk);
      start = 1'b0; ent_vld = 1'b0;

      // Overflow: columns 0 and 1 full, then (r0,c2) must open col 2 and trap.
      mon_clear();
      do_start();
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 4; r++)
            send(r, c, 0);
      @(negedge clk);
      ent_vld = 1'b1; ent_row = 2'd0; ent_col = 2'd2; ent_last = 1'b0;
      rdy_seen = 0;
      repeat (4) begin
         #1 if (ent_rdy) rdy_seen++;
         @(negedge clk);
      end
      check("ovf_rdy_never", 32'(rdy_seen), 32'd0);
      check("ovf_err", 32'(err), 32'd1);
      check("ovf_nnz", 32'(nnz), 32'd8);
      check("ovf_busy", 32'(busy), 32'd0);
      check("ovf_ptr0", 32'(ptr_mem[0]), 32'd0);
      check("ovf_ptr1", 32'(ptr_mem[1]), 32'd4);
      check("ovf_ptr2", 32'(ptr_mem[2]), 32'd8);
      check("ovf_ptr3_unwritten", 32'(ptr_mem[3]), 32'hF);
      ent_vld = 1'b0;
      do_start();
      check("ovf_start_clears_err", 32'(err), 32'd0);
      check("ovf_start_busy", 32'(busy), 32'd1);

      // Reset during FLUSH, then the basic load again from scratch.
      send(0, 0, 0);
      send(2, 0, 0);
      send(1, 2, 1);
      @(negedge clk);
      ent_vld = 1'b0;
      @(posedge clk);
      #1 check("flush_in_progress", 32'({ptr_we, busy, ptr_addr}), 32'({1'b1, 1'b1, 3'd3}));
      @(negedge clk);
      rst_n = 1'b0;
      mon_clr = 1'b1;
      #1 check("rst_flush_outputs_now", all_outs(), 32'd0);
      repeat (2) @(posedge clk);
      #1 check("rst_flush_outputs_held", all_outs(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 mon_clr = 1'b0;
      check("rst_flush_idle", all_outs(), 32'd0);

      do_start();
      send(0, 0, 0);
      send(2, 0, 0);
      send(1, 2, 1);
      @(negedge clk);
      ent_vld = 1'b0;
      for (int k = 0; k < 20 && done_cnt == 0; k++) @(negedge clk);
      check("rerun_done_seen", 32'(done_cnt > 0), 32'd1);
      repeat (3) @(negedge clk);
      check("rerun_done_once", 32'(done_cnt), 32'd1);
      for (int i = 0; i < 5; i++)
         check($sformatf("rerun_ptr%0d", i), 32'(ptr_mem[i]), 32'(exp_ptr[i]));
      for (int i = 0; i < 3; i++)
         check($sformatf("rerun_row%0d", i), 32'(row_mem[i]), 32'(exp_row[i]));
      check("rerun_nnz", 32'(nnz), 32'd3);
      check("rerun_err", 32'(err), 32'd0);
      check("rerun_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
